vga_ctrl: RTL and testbench
===========================

# vga_ctrl

Video timing controller that sequences the three per-channel TMDS encoders of the HDMI transmitter. It generates hsync/vsync/de from horizontal and vertical counters and requests pixels from the frame source one cycle ahead. It expands returned RGB565 into 8-bit red/green/blue lanes aligned with de. A run/stop state machine guarantees that output only starts and stops on whole-frame boundaries.

## Interface
- H_SYNC, 96: hsync width, pixels
- H_BACK, 48: horizontal back porch
- H_VALID, 640: active pixels per line
- H_FRONT, 16: horizontal front porch
- V_SYNC, 2: vsync width, lines
- V_BACK, 33: vertical back porch
- V_VALID, 480: active lines
- V_FRONT, 10: vertical front porch
- SYNC_POL, 1'b1: asserted level of hsync/vsync

Ports:
- vga_clk  in  1  pixel clock, single clock domain
- sys_rst_n  in  1  asynchronous active-low reset
- en  in  1  run request, level
- pix_data  in  16  RGB565 from source, valid the cycle after pix_req
- pix_req  out  1  pixel request
- pix_x  out  10  column of requested pixel, 10'h3FF when pix_req=0
- pix_y  out  10  row of requested pixel, 10'h3FF when pix_req=0
- hsync  out  1  to encoder c0
- vsync  out  1  to encoder c1
- de  out  1  data enable
- red, green, blue  out  8 each  encoder data_in lanes
- frame_start  out  1  one-cycle pulse at start of each frame
- busy  out  1  high in RUN or DRAIN

## Operation
- H_TOTAL = sum of H parameters (800 by default). V_TOTAL = sum of V parameters (525 by default).
- Line order is sync, back porch, active, front porch. Frame order is the same.
- cnt_h runs 0..H_TOTAL-1. cnt_v increments when cnt_h wraps and itself wraps at V_TOTAL-1.
- Both counters are 10-bit unsigned and hold at 0 outside RUN/DRAIN.
- Active window: cnt_h in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_VALID) and cnt_v in [V_SYNC+V_BACK, V_SYNC+V_BACK+V_VALID).
- pix_req is combinational from the counters and is high exactly in the active window.
- pix_x = cnt_h-(H_SYNC+H_BACK). pix_y = cnt_v-(V_SYNC+V_BACK).
- hsync and de are registered decodes of the counters:
  - hsync = SYNC_POL when cnt_h < H_SYNC.
  - de = the registered value of pix_req.
- vsync = SYNC_POL when cnt_v < V_SYNC. It changes together with hsync at line start.
- RGB565 expansion: red = {r5,r5[4:2]}, green = {g6,g6[5:4]}, blue = {b5,b5[4:2]}. It is combinational from pix_data and gated to 0 when de=0.
- State machine IDLE / RUN / DRAIN:
  - IDLE: counters 0, hsync/vsync = ~SYNC_POL, de=0. en=1 → RUN, starting at cnt_h=cnt_v=0.
  - RUN: en=0 → DRAIN.
  - DRAIN: the current frame completes. en=1 → RUN with no counter disturbance. At cnt_h=H_TOTAL-1 and cnt_v=V_TOTAL-1 with en=0 → IDLE.
- frame_start is registered and pulses on the cycle after the counters read (0,0) in RUN/DRAIN.

## Timing
- Reset values: pix_req=0, pix_x=pix_y=10'h3FF, hsync=vsync=~SYNC_POL, de=0, red/green/blue=0, frame_start=0, busy=0, state IDLE.
- Reset asserted mid-frame takes effect immediately (asynchronous). After release the block restarts from IDLE.
- pix_req at cycle N → de and RGB valid at cycle N+1. The source has exactly one cycle of latency.
- hsync/vsync/de/RGB share one register stage, so the encoder's internal pipeline keeps them aligned.
- en rising in IDLE → busy=1 and first counter value (0,0) on the next cycle. frame_start follows one cycle later.
- Stop is never mid-line or mid-frame. The last cycle of DRAIN is the final front-porch pixel.

## Structure
- Shared package hdmi_pkg holds: default 640x480@60 timing constants, derived H_TOTAL/V_TOTAL/active-start constants, state encoding (IDLE=2'd0, RUN=2'd1, DRAIN=2'd2), and the RGB565→888 expansion function.
- A single sub-module is natural: timing_cnt, the cascaded h/v counter with enable and wrap flags. State machine, decode and output registers stay in vga_ctrl.

## Test plan
- Reset then en=1 for 2 frames → 800 cycles per line, 525 lines per frame, hsync asserted 96 cycles per line, vsync asserted 1600 cycles per frame.
- Active window → first pix_req at cnt_h=144, cnt_v=35 with pix_x=0, pix_y=0. Last pix_req at pix_x=639, pix_y=479. Exactly 307200 de cycles per frame.
- Source returns pix_data = 16'hF800 the cycle after each pix_req → red=8'hFF, green=0, blue=0 with de=1. 16'h07E0 → green=8'hFF.
- en dropped at cnt_v=100 → frame runs to cnt_v=524, cnt_h=799, then IDLE with busy=0, de=0, hsync=vsync=~SYNC_POL. en re-raised during DRAIN → no gap, next frame_start exactly 420000 cycles after the previous one.
- sys_rst_n pulsed low mid-active-line → same cycle de=0, pix_req=0, RGB=0. After release with en=1, frame_start fires 2 cycles later.
- SYNC_POL=0 build → hsync/vsync idle high and low during sync; all other timing identical.

Source files
------------

// File: rtl/hdmi_pkg.sv
// Shared HDMI video constants, controller state encoding and pixel format helpers.
// Defaults describe 640x480@60 with a 25.175 MHz pixel clock.
package hdmi_pkg;

  localparam int unsigned DEF_H_SYNC  = 96;
  localparam int unsigned DEF_H_BACK  = 48;
  localparam int unsigned DEF_H_VALID = 640;
  localparam int unsigned DEF_H_FRONT = 16;
  localparam int unsigned DEF_V_SYNC  = 2;
  localparam int unsigned DEF_V_BACK  = 33;
  localparam int unsigned DEF_V_VALID = 480;
  localparam int unsigned DEF_V_FRONT = 10;

  localparam int unsigned DEF_H_TOTAL     = DEF_H_SYNC + DEF_H_BACK + DEF_H_VALID + DEF_H_FRONT;
  localparam int unsigned DEF_V_TOTAL     = DEF_V_SYNC + DEF_V_BACK + DEF_V_VALID + DEF_V_FRONT;
  localparam int unsigned DEF_H_ACT_START = DEF_H_SYNC + DEF_H_BACK;
  localparam int unsigned DEF_V_ACT_START = DEF_V_SYNC + DEF_V_BACK;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } vga_state_e;

  // Replicating the top bits maps full-scale 565 codes onto full-scale 8-bit lanes.
  function automatic logic [23:0] rgb565_to_888(input logic [15:0] pix);
    return {pix[15:11], pix[15:13], pix[10:5], pix[10:9], pix[4:0], pix[4:2]};
  endfunction

endpackage

// File: rtl/vga_ctrl_if.sv
// Pixel request/return bus between the timing controller and the frame source.
interface vga_ctrl_if;
  logic        pix_req;
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic [15:0] pix_data;

  modport master (output pix_req, output pix_x, output pix_y, input pix_data);
  modport slave  (input pix_req, input pix_x, input pix_y, output pix_data);
endinterface

// File: rtl/vga_ctrl_timing_cnt.sv
// Cascaded horizontal/vertical raster counter with frame-end flag.
// Counters sit at the origin whenever run is low.
module timing_cnt
  import hdmi_pkg::*;
#(
  parameter int unsigned H_TOTAL = DEF_H_TOTAL,
  parameter int unsigned V_TOTAL = DEF_V_TOTAL
) (
  input  logic       vga_clk,
  input  logic       sys_rst_n,
  input  logic       run,
  output logic [9:0] cnt_h,
  output logic [9:0] cnt_v,
  output logic       frame_end
);

  logic [9:0] cnt_h_r;
  logic [9:0] cnt_v_r;
  logic       line_end_s;

  assign line_end_s = (cnt_h_r == 10'(H_TOTAL - 1));
  assign frame_end  = line_end_s && (cnt_v_r == 10'(V_TOTAL - 1));
  assign cnt_h      = cnt_h_r;
  assign cnt_v      = cnt_v_r;

  // Raster position register: h advances every cycle, v on each line wrap.
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_h_r <= 10'd0;
      cnt_v_r <= 10'd0;
    end else if (!run) begin
      cnt_h_r <= 10'd0;
      cnt_v_r <= 10'd0;
    end else if (line_end_s) begin
      cnt_h_r <= 10'd0;
      cnt_v_r <= frame_end ? 10'd0 : (cnt_v_r + 10'd1);
    end else begin
      cnt_h_r <= cnt_h_r + 10'd1;
    end
  end

endmodule

// File: rtl/vga_ctrl.sv
// Video timing controller feeding the three TMDS encoders: sync/de generation,
// one-ahead pixel requests, RGB565 expansion and frame-aligned run/stop control.
module vga_ctrl
  import hdmi_pkg::*;
#(
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BACK   = DEF_H_BACK,
  parameter int unsigned H_VALID  = DEF_H_VALID,
  parameter int unsigned H_FRONT  = DEF_H_FRONT,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BACK   = DEF_V_BACK,
  parameter int unsigned V_VALID  = DEF_V_VALID,
  parameter int unsigned V_FRONT  = DEF_V_FRONT,
  parameter logic        SYNC_POL = 1'b1
) (
  input  logic       vga_clk,
  input  logic       sys_rst_n,
  input  logic       en,
  vga_ctrl_if.master pix_bus,
  output logic       hsync,
  output logic       vsync,
  output logic       de,
  output logic [7:0] red,
  output logic [7:0] green,
  output logic [7:0] blue,
  output logic       frame_start,
  output logic       busy
);

  localparam int unsigned H_TOTAL = H_SYNC + H_BACK + H_VALID + H_FRONT;
  localparam int unsigned V_TOTAL = V_SYNC + V_BACK + V_VALID + V_FRONT;
  localparam int unsigned H_ACT   = H_SYNC + H_BACK;
  localparam int unsigned V_ACT   = V_SYNC + V_BACK;

  vga_state_e  state_r;
  vga_state_e  state_nxt_s;
  logic        run_s;
  logic [9:0]  cnt_h_s;
  logic [9:0]  cnt_v_s;
  logic        frame_end_s;
  logic        pix_req_s;
  logic        hsync_r;
  logic        vsync_r;
  logic        de_r;
  logic        frame_start_r;
  logic [23:0] rgb_s;

  assign run_s = (state_r != IDLE);

  timing_cnt #(
    .H_TOTAL (H_TOTAL),
    .V_TOTAL (V_TOTAL)
  ) u_timing_cnt (
    .vga_clk   (vga_clk),
    .sys_rst_n (sys_rst_n),
    .run       (run_s),
    .cnt_h     (cnt_h_s),
    .cnt_v     (cnt_v_s),
    .frame_end (frame_end_s)
  );

  // Run/stop state register.
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state: stopping is only honoured on the last pixel of a frame.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:    state_nxt_s = en ? RUN : IDLE;
      RUN:     state_nxt_s = en ? RUN : DRAIN;
      DRAIN: begin
        if (en) begin
          state_nxt_s = RUN;
        end else if (frame_end_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DRAIN;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  assign pix_req_s = run_s
                  && (cnt_h_s >= 10'(H_ACT)) && (cnt_h_s < 10'(H_ACT + H_VALID))
                  && (cnt_v_s >= 10'(V_ACT)) && (cnt_v_s < 10'(V_ACT + V_VALID));

  assign pix_bus.pix_req = pix_req_s;
  assign pix_bus.pix_x   = pix_req_s ? (cnt_h_s - 10'(H_ACT)) : 10'h3FF;
  assign pix_bus.pix_y   = pix_req_s ? (cnt_v_s - 10'(V_ACT)) : 10'h3FF;

  // One register stage for sync, de and frame marker, matching the source's latency.
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      hsync_r       <= ~SYNC_POL;
      vsync_r       <= ~SYNC_POL;
      de_r          <= 1'b0;
      frame_start_r <= 1'b0;
    end else begin
      hsync_r       <= (run_s && (cnt_h_s < 10'(H_SYNC))) ? SYNC_POL : ~SYNC_POL;
      vsync_r       <= (run_s && (cnt_v_s < 10'(V_SYNC))) ? SYNC_POL : ~SYNC_POL;
      de_r          <= pix_req_s;
      frame_start_r <= run_s && (cnt_h_s == 10'd0) && (cnt_v_s == 10'd0);
    end
  end

  assign rgb_s       = rgb565_to_888(pix_bus.pix_data);
  assign red         = de_r ? rgb_s[23:16] : 8'd0;
  assign green       = de_r ? rgb_s[15:8]  : 8'd0;
  assign blue        = de_r ? rgb_s[7:0]   : 8'd0;
  assign hsync       = hsync_r;
  assign vsync       = vsync_r;
  assign de          = de_r;
  assign frame_start = frame_start_r;
  assign busy        = run_s;

endmodule

// File: tb/tb_vga_ctrl.sv
// Randomised bench for vga_ctrl on a shrunken raster, compared each cycle against
// a frame-position reference model; a second instance covers active-low sync.
module tb_vga_ctrl;

  localparam int HS = 4, HB = 3, HV = 8, HF = 2;
  localparam int VS = 2, VB = 2, VV = 5, VF = 1;
  localparam int HT = HS + HB + HV + HF;
  localparam int VT = VS + VB + VV + VF;
  localparam int FRAME = HT * VT;

  logic       vga_clk = 1'b0;
  logic       sys_rst_n = 1'b1;
  logic       en = 1'b0;
  logic       hsync, vsync, de, frame_start, busy;
  logic [7:0] red, green, blue;
  logic       hsync0, vsync0, de0, frame_start0, busy0;
  logic [7:0] red0, green0, blue0;

  vga_ctrl_if bus ();
  vga_ctrl_if bus0 ();

  vga_ctrl #(
    .H_SYNC(HS), .H_BACK(HB), .H_VALID(HV), .H_FRONT(HF),
    .V_SYNC(VS), .V_BACK(VB), .V_VALID(VV), .V_FRONT(VF), .SYNC_POL(1'b1)
  ) u_dut (
    .vga_clk(vga_clk), .sys_rst_n(sys_rst_n), .en(en), .pix_bus(bus),
    .hsync(hsync), .vsync(vsync), .de(de), .red(red), .green(green), .blue(blue),
    .frame_start(frame_start), .busy(busy)
  );

  vga_ctrl #(
    .H_SYNC(HS), .H_BACK(HB), .H_VALID(HV), .H_FRONT(HF),
    .V_SYNC(VS), .V_BACK(VB), .V_VALID(VV), .V_FRONT(VF), .SYNC_POL(1'b0)
  ) u_dut0 (
    .vga_clk(vga_clk), .sys_rst_n(sys_rst_n), .en(en), .pix_bus(bus0),
    .hsync(hsync0), .vsync(vsync0), .de(de0), .red(red0), .green(green0), .blue(blue0),
    .frame_start(frame_start0), .busy(busy0)
  );

  always #5 vga_clk = ~vga_clk;

  int checks = 0;
  int failures = 0;

  task automatic check_val(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: position within the frame plus run/drain bookkeeping.
  int m_pos;
  bit m_busy, m_drain, m_hs_a, m_vs_a, m_de, m_fs;

  function automatic bit in_window(input int pos);
    int h;
    int v;
    h = pos % HT;
    v = pos / HT;
    return (h >= HS + HB) && (h < HS + HB + HV) && (v >= VS + VB) && (v < VS + VB + VV);
  endfunction

  function automatic int exp_req();
    return (m_busy && in_window(m_pos)) ? 1 : 0;
  endfunction

  function automatic int exp_x();
    return (exp_req() != 0) ? (m_pos % HT) - (HS + HB) : 32'h3FF;
  endfunction

  function automatic int exp_y();
    return (exp_req() != 0) ? (m_pos / HT) - (VS + VB) : 32'h3FF;
  endfunction

  function automatic int exp_lane(input int pix, input int lane);
    int r5, g6, b5;
    r5 = (pix / 2048) % 32;
    g6 = (pix / 32) % 64;
    b5 = pix % 32;
    if (!m_de) return 0;
    case (lane)
      0:       return r5 * 8 + r5 / 4;
      1:       return g6 * 4 + g6 / 16;
      2:       return b5 * 8 + b5 / 4;
      default: return 0;
    endcase
  endfunction

  always @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      m_pos <= 0; m_busy <= 1'b0; m_drain <= 1'b0;
      m_hs_a <= 1'b0; m_vs_a <= 1'b0; m_de <= 1'b0; m_fs <= 1'b0;
    end else begin
      m_hs_a <= m_busy && ((m_pos % HT) < HS);
      m_vs_a <= m_busy && ((m_pos / HT) < VS);
      m_de   <= m_busy && in_window(m_pos);
      m_fs   <= m_busy && (m_pos == 0);
      if (!m_busy) begin
        if (en) begin
          m_busy <= 1'b1;
          m_pos  <= 0;
        end
        m_drain <= 1'b0;
      end else begin
        if (m_drain && !en && (m_pos == FRAME - 1)) m_busy <= 1'b0;
        m_pos   <= (m_pos + 1) % FRAME;
        m_drain <= !en;
      end
    end
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge vga_clk) begin
    check_val("pix_req", 32'(bus.pix_req), exp_req());
    check_val("pix_x", 32'(bus.pix_x), exp_x());
    check_val("pix_y", 32'(bus.pix_y), exp_y());
    check_val("hsync", 32'(hsync), 32'(m_hs_a));
    check_val("vsync", 32'(vsync), 32'(m_vs_a));
    check_val("de", 32'(de), 32'(m_de));
    check_val("red", 32'(red), exp_lane(32'(bus.pix_data), 0));
    check_val("green", 32'(green), exp_lane(32'(bus.pix_data), 1));
    check_val("blue", 32'(blue), exp_lane(32'(bus.pix_data), 2));
    check_val("frame_start", 32'(frame_start), 32'(m_fs));
    check_val("busy", 32'(busy), 32'(m_busy));
    check_val("pol0_hsync", 32'(hsync0), 32'(!m_hs_a));
    check_val("pol0_vsync", 32'(vsync0), 32'(!m_vs_a));
    check_val("pol0_de", 32'(de0), 32'(m_de));
    check_val("pol0_pix_req", 32'(bus0.pix_req), exp_req());
    check_val("pol0_red", 32'(red0), exp_lane(32'(bus0.pix_data), 0));
    check_val("pol0_green", 32'(green0), exp_lane(32'(bus0.pix_data), 1));
    check_val("pol0_blue", 32'(blue0), exp_lane(32'(bus0.pix_data), 2));
    check_val("pol0_frame_start", 32'(frame_start0), 32'(m_fs));
    check_val("pol0_busy", 32'(busy0), 32'(m_busy));
  end

  // Whole-frame totals between consecutive frame_start pulses of an unbroken run.
  int  agg_cyc, agg_de, agg_hs, agg_vs;
  bit  have_prev;
  always @(negedge vga_clk) begin
    if (!sys_rst_n || !busy) begin
      have_prev <= 1'b0;
      agg_cyc <= 0; agg_de <= 0; agg_hs <= 0; agg_vs <= 0;
    end else if (frame_start) begin
      if (have_prev) begin
        check_val("frame_period", agg_cyc, FRAME);
        check_val("de_per_frame", agg_de, HV * VV);
        check_val("hsync_per_frame", agg_hs, HS * VT);
        check_val("vsync_per_frame", agg_vs, VS * HT);
      end
      have_prev <= 1'b1;
      agg_cyc <= 1;
      agg_de  <= 32'(de);
      agg_hs  <= 32'(hsync);
      agg_vs  <= 32'(vsync);
    end else begin
      agg_cyc <= agg_cyc + 1;
      agg_de  <= agg_de + 32'(de);
      agg_hs  <= agg_hs + 32'(hsync);
      agg_vs  <= agg_vs + 32'(vsync);
    end
  end

  // Advance one cycle, then drive en and a fresh source word off the clock edge.
  task automatic step(input bit en_v);
    logic [15:0] d;
    @(negedge vga_clk);
    #1;
    case ($urandom_range(3))
      0:       d = 16'hF800;
      1:       d = 16'h07E0;
      default: d = 16'($urandom);
    endcase
    en = en_v;
    bus.pix_data  = d;
    bus0.pix_data = d;
  endtask

  initial begin
    bit en_v;
    bus.pix_data  = 16'h0000;
    bus0.pix_data = 16'h0000;
    #1 sys_rst_n = 1'b0;
    #2;
    check_val("rst_pix_req", 32'(bus.pix_req), 0);
    check_val("rst_pix_x", 32'(bus.pix_x), 32'h3FF);
    check_val("rst_pix_y", 32'(bus.pix_y), 32'h3FF);
    check_val("rst_hsync", 32'(hsync), 0);
    check_val("rst_vsync", 32'(vsync), 0);
    check_val("rst_pol0_hsync", 32'(hsync0), 1);
    check_val("rst_de", 32'(de), 0);
    check_val("rst_rgb", 32'({red, green, blue}), 0);
    check_val("rst_frame_start", 32'(frame_start), 0);
    check_val("rst_busy", 32'(busy), 0);
    repeat (3) step(1'b0);
    @(negedge vga_clk);
    #1 sys_rst_n = 1'b1;

    repeat (3 * FRAME) step(1'b1);

    // Drop en mid-frame, then re-raise it before the frame drains out.
    for (int i = 0; i < 2 * FRAME && (m_pos / HT != 5); i++) step(1'b1);
    check_val("drop_point_reached", m_pos / HT, 5);
    repeat (2 * HT) step(1'b0);
    check_val("drain_still_busy", 32'(busy), 1);
    repeat (2 * FRAME) step(1'b1);

    for (int i = 0; i < 2 * FRAME && busy; i++) step(1'b0);
    check_val("stop_busy", 32'(busy), 0);
    check_val("stop_de", 32'(de), 0);
    check_val("stop_hsync", 32'(hsync), 0);
    check_val("stop_vsync", 32'(vsync), 0);
    check_val("stop_pol0_vsync", 32'(vsync0), 1);
    repeat (20) step(1'b0);

    en_v = 1'b0;
    repeat (3000) begin
      if ($urandom_range(39) == 0) en_v = ~en_v;
      step(en_v);
    end

    // Asynchronous reset in the middle of an active line.
    for (int i = 0; i < 3 * FRAME && !(bus.pix_req && de); i++) step(1'b1);
    check_val("active_line_reached", 32'(bus.pix_req && de), 1);
    #1 sys_rst_n = 1'b0;
    #1;
    check_val("async_rst_de", 32'(de), 0);
    check_val("async_rst_pix_req", 32'(bus.pix_req), 0);
    check_val("async_rst_rgb", 32'({red, green, blue}), 0);
    check_val("async_rst_busy", 32'(busy), 0);
    repeat (3) step(1'b1);
    @(negedge vga_clk);
    #1;
    sys_rst_n = 1'b1;
    en = 1'b1;
    @(posedge vga_clk);
    #1;
    check_val("restart_busy", 32'(busy), 1);
    check_val("restart_fs_early", 32'(frame_start), 0);
    @(posedge vga_clk);
    #1;
    check_val("restart_fs", 32'(frame_start), 1);
    repeat (FRAME + 5) step(1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
